// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
//
// Shares the NES CPU-side bus (WRAM, PPU register port, cart PRG) between the
// rp2a03 CPU and one host master (debug / save-state port). A host request
// stalls the CPU through RDY. Once the 6502 is frozen in a read cycle, the
// arbiter runs single-byte host accesses. It then returns the bus with one
// refetch cycle, so the CPU's halted read completes with fresh data.
//
// Ports
//   clk_25        system clock, rising edge
//   rst           asynchronous, active-high reset
//   cpu_a_in      rp2a03 address
//   cpu_d_in      rp2a03 write data
//   cpu_r_nw_in   rp2a03 read/not-write
//   ext_rdy_in    external RDY request, ANDed into rdy_out
//   rdy_out       to rp2a03 rdy_in
//   bus_a_out     address to WRAM/PPU/cart decode
//   bus_d_out     write data to WRAM/PPU/cart
//   bus_r_nw_out  read/not-write to WRAM/PPU/cart
//   bus_d_in      merged read data from the bus
//   host_req      level request; host_we/host_a/host_d stable until host_ack
//   host_we       1 = write, 0 = read
//   host_a        host address
//   host_d        host write data
//   host_ack      one-cycle completion pulse
//   host_q        read data captured in DATA, held until the next capture
//   grant_out     high while the host owns the bus (ACCESS through GAP)
//
// state   | meaning
// IDLE    | CPU owns bus, rdy released
// STALL   | rdy pulled low, waiting for the CPU to sit in a read cycle
// ACCESS  | host address (and write strobe) on the bus
// DATA    | read data valid on bus_d_in, captured into host_q
// ACK     | host_ack pulse
// GAP     | continue a burst if host_req is still high, else release
// RELEASE | CPU address back on the bus with rdy low so its read is refetched

module cpu_bus_arbiter (
  input  logic        clk_25,
  input  logic        rst,
  input  logic [15:0] cpu_a_in,
  input  logic [7:0]  cpu_d_in,
  input  logic        cpu_r_nw_in,
  input  logic        ext_rdy_in,
  output logic        rdy_out,
  output logic [15:0] bus_a_out,
  output logic [7:0]  bus_d_out,
  output logic        bus_r_nw_out,
  input  logic [7:0]  bus_d_in,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_a,
  input  logic [7:0]  host_d,
  output logic        host_ack,
  output logic [7:0]  host_q,
  output logic        grant_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STALL   = 3'd1,
    ACCESS  = 3'd2,
    DATA    = 3'd3,
    ACK     = 3'd4,
    GAP     = 3'd5,
    RELEASE = 3'd6
  } state_t;

  state_t state;
  logic   rdy_int;

  // rdy_int, grant_out and host_ack are updated together with the state, so
  // each one always reflects the state it belongs to.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rdy_int   <= 1'b1;
      host_ack  <= 1'b0;
      host_q    <= 8'h00;
      grant_out <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (host_req) begin
            state   <= STALL;
            rdy_int <= 1'b0;
          end
        end
        STALL: begin
          // A 6502 ignores RDY during writes, so wait until it is reading.
          if (cpu_r_nw_in && !rdy_int) begin
            state     <= ACCESS;
            grant_out <= 1'b1;
          end
        end
        ACCESS: state <= DATA;
        DATA: begin
          host_q   <= bus_d_in;
          host_ack <= 1'b1;
          state    <= ACK;
        end
        ACK: state <= GAP;
        GAP: begin
          if (host_req) begin
            state <= ACCESS;
          end else begin
            state     <= RELEASE;
            grant_out <= 1'b0;
          end
        end
        RELEASE: begin
          state   <= IDLE;
          rdy_int <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          rdy_int   <= 1'b1;
          grant_out <= 1'b0;
        end
      endcase
    end
  end

  assign rdy_out = ext_rdy_in & rdy_int;

  // grant_out is high exactly in ACCESS..GAP, so it selects the host side.
  // The write strobe is limited to ACCESS: one strobe per host write.
  assign bus_a_out    = grant_out ? host_a : cpu_a_in;
  assign bus_d_out    = grant_out ? host_d : cpu_d_in;
  assign bus_r_nw_out = grant_out ? ((state == ACCESS) ? ~host_we : 1'b1)
                                  : cpu_r_nw_in;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;

  localparam int MAXC = 16384;

  logic        clk_25 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_a_in = 16'h0000;
  logic [7:0]  cpu_d_in = 8'h00;
  logic        cpu_r_nw_in = 1'b1;
  logic        ext_rdy_in = 1'b1;
  logic        rdy_out;
  logic [15:0] bus_a_out;
  logic [7:0]  bus_d_out;
  logic        bus_r_nw_out;
  logic [7:0]  bus_d_in;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_a = 16'h0000;
  logic [7:0]  host_d = 8'h00;
  logic        host_ack;
  logic [7:0]  host_q;
  logic        grant_out;

  cpu_bus_arbiter dut (
    .clk_25(clk_25), .rst(rst),
    .cpu_a_in(cpu_a_in), .cpu_d_in(cpu_d_in), .cpu_r_nw_in(cpu_r_nw_in),
    .ext_rdy_in(ext_rdy_in), .rdy_out(rdy_out),
    .bus_a_out(bus_a_out), .bus_d_out(bus_d_out), .bus_r_nw_out(bus_r_nw_out),
    .bus_d_in(bus_d_in),
    .host_req(host_req), .host_we(host_we), .host_a(host_a), .host_d(host_d),
    .host_ack(host_ack), .host_q(host_q), .grant_out(grant_out)
  );

  always #20 clk_25 = ~clk_25;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Synchronous RAM covering the whole CPU space.
  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] a_q = 16'h0000;
  assign bus_d_in = mem[a_q];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
    end
    mem[16'h0300] = 8'hC3;
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
    forever begin
      @(posedge clk_25);
      if (!bus_r_nw_out) mem[bus_a_out] <= bus_d_out;
      a_q <= bus_a_out;
    end
  end

  // Scoreboard of host transactions.
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  expq;
    int          exp_cyc;
  } txn_t;
  txn_t sb[$];

  // Cycle logs for directed timing checks.
  logic        rdy_log   [0:MAXC-1];
  logic        rnw_log   [0:MAXC-1];
  logic        grant_log [0:MAXC-1];
  logic [15:0] ba_log    [0:MAXC-1];

  int   host_strobes = 0, strobes_at_ack = 0, cpu_strobes = 0, ack_count = 0;
  logic prev_grant = 1'b0, prev_cpu_rnw = 1'b1;

  always @(negedge clk_25) begin
    txn_t e;
    if (cyc < MAXC) begin
      rdy_log[cyc]   = rdy_out;
      rnw_log[cyc]   = bus_r_nw_out;
      grant_log[cyc] = grant_out;
      ba_log[cyc]    = bus_a_out;
    end
    if (grant_out) begin
      chk("grant_rdy_low", rdy_out, 0);
      chk("grant_bus_a", bus_a_out, host_a);
      chk("grant_bus_d", bus_d_out, host_d);
      if (!bus_r_nw_out) host_strobes++;
      if (!prev_grant) chk("grant_after_cpu_read", prev_cpu_rnw, 1);
    end else begin
      chk("cpu_pass_a", bus_a_out, cpu_a_in);
      chk("cpu_pass_rnw", bus_r_nw_out, cpu_r_nw_in);
      if (!bus_r_nw_out) cpu_strobes++;
    end
    if (host_ack) begin
      ack_count++;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = sb.pop_front();
        if (!e.we) chk("host_q", host_q, e.expq);
        else ref_mem[e.addr] = e.data;
        chk("host_strobes_per_txn", host_strobes - strobes_at_ack, e.we ? 1 : 0);
        if (e.exp_cyc >= 0) chk("ack_cycle", cyc, e.exp_cyc);
      end
      strobes_at_ack = host_strobes;
    end
    prev_grant   = grant_out;
    prev_cpu_rnw = cpu_r_nw_in;
  end

  // CPU model: a 6502 halts only on reads while RDY is low; writes run on.
  int          cpu_mode = 0;          // 0 = read loop on cpu_fix_addr, 1 = random
  logic [15:0] cpu_fix_addr = 16'h0000;
  int          force_push = 0;
  bit          cpu_chk_en = 1'b1;
  int          cpu_wr_issued = 0;
  int          cpu_rd_chks = 0;
  logic [7:0]  last_cpu_rd = 8'h00;

  initial begin
    int   held, pend_w;
    logic s_rdy;
    logic [7:0] s_d;
    held = 0;
    pend_w = 0;
    forever begin
      @(negedge clk_25);
      s_rdy = rdy_out;
      s_d   = bus_d_in;
      @(posedge clk_25);
      #1;
      if (rst) begin
        held = 0;
      end else if (cpu_r_nw_in && !s_rdy) begin
        held++;
      end else begin
        if (cpu_r_nw_in && held > 0 && cpu_chk_en) begin
          chk("cpu_halted_read", s_d, ref_mem[cpu_a_in]);
          last_cpu_rd = s_d;
          cpu_rd_chks++;
        end
        held = 0;
        if (force_push > 0) begin
          pend_w = force_push;
          force_push = 0;
        end else if (cpu_mode == 1 && pend_w == 0 && $urandom_range(0, 7) == 0) begin
          pend_w = $urandom_range(1, 3);
        end
        if (pend_w > 0) begin
          pend_w--;
          cpu_r_nw_in = 1'b0;
          cpu_a_in    = 16'h0400 + 16'($urandom_range(0, 15));
          cpu_d_in    = 8'($urandom);
          ref_mem[cpu_a_in] = cpu_d_in;
          cpu_wr_issued++;
        end else if (cpu_mode == 0) begin
          cpu_r_nw_in = 1'b1;
          cpu_a_in    = cpu_fix_addr;
        end else begin
          cpu_r_nw_in = 1'b1;
          cpu_a_in    = ($urandom_range(0, 1) == 1)
                        ? 16'h0300 + 16'($urandom_range(0, 31))
                        : 16'h0400 + 16'($urandom_range(0, 15));
        end
      end
    end
  end

  bit ext_rand = 1'b0;
  initial forever begin
    @(posedge clk_25);
    #2;
    if (ext_rand) ext_rdy_in = ($urandom_range(0, 7) != 0);
  end

  // Host driver: n accesses to a0.., data d0.., host_req held through the burst.
  task automatic host_seq(input int n, input logic we, input logic [15:0] a0,
                          input logic [7:0] d0, input bit timed, output int n0);
    txn_t e;
    int   t;
    @(posedge clk_25);
    #2;
    n0 = cyc;
    for (int i = 0; i < n; i++) begin
      host_req = 1'b1;
      host_we  = we;
      host_a   = a0 + 16'(i);
      host_d   = d0 + 8'(i);
      e.we      = we;
      e.addr    = host_a;
      e.data    = host_d;
      e.expq    = ref_mem[host_a];
      e.exp_cyc = timed ? n0 + 4 + 4 * i : -1;
      sb.push_back(e);
      t = 0;
      do begin
        @(negedge clk_25);
        t++;
      end while (!host_ack && t < 60);
      if (!host_ack) chk("host_ack_timeout", 0, 1);
      @(posedge clk_25);
      #2;
    end
    host_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, rd_before;
    repeat (3) @(posedge clk_25);
    @(negedge clk_25);
    chk("reset_rdy", rdy_out, 1);
    chk("reset_ack", host_ack, 0);
    chk("reset_q", host_q, 0);
    chk("reset_grant", grant_out, 0);
    chk("reset_bus_a", bus_a_out, cpu_a_in);
    @(posedge clk_25);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk_25);

    // Single write, CPU looping on a read of $0000.
    host_seq(1, 1'b1, 16'h0123, 8'h5A, 1'b1, n0);
    repeat (5) @(negedge clk_25);
    for (int k = 1; k <= 6; k++) chk("single_rdy_low", rdy_log[n0 + k], 0);
    chk("single_rdy_back", rdy_log[n0 + 7], 1);
    chk("single_rdy_n", rdy_log[n0], 1);
    for (int k = 0; k <= 7; k++) chk("single_strobe", rnw_log[n0 + k], (k == 2) ? 0 : 1);
    chk("single_strobe_addr", ba_log[n0 + 2], 16'h0123);
    chk("wram_0123", mem[16'h0123], 8'h5A);

    // Read it back.
    host_seq(1, 1'b0, 16'h0123, 8'h00, 1'b1, n0);
    repeat (4) @(posedge clk_25);
    chk("q_held", host_q, 8'h5A);

    // Reset while in DATA.
    cpu_chk_en = 1'b0;
    host_seq(1, 1'b0, 16'h0123, 8'h00, 1'b0, n0);
    sb.delete();
    @(posedge clk_25);
    #2;
    chk("rst_test_in_access", grant_out, 0);
    repeat (3) @(posedge clk_25);
    #2;
    n0 = ack_count;
    host_req = 1'b1;
    host_we  = 1'b0;
    host_a   = 16'h0123;
    repeat (3) @(posedge clk_25);
    #2;
    ext_rdy_in = 1'b0;
    rst = 1'b1;
    host_req = 1'b0;
    @(negedge clk_25);
    chk("rst_mid_grant", grant_out, 0);
    chk("rst_mid_rdy", rdy_out, 0);
    chk("rst_mid_q", host_q, 0);
    chk("rst_mid_bus_a", bus_a_out, cpu_a_in);
    @(posedge clk_25);
    #2;
    rst = 1'b0;
    ext_rdy_in = 1'b1;
    @(negedge clk_25);
    chk("rst_after_rdy", rdy_out, 1);
    repeat (10) @(negedge clk_25);
    chk("rst_no_ack", ack_count, n0);
    chk("rst_q_zero", host_q, 0);
    cpu_chk_en = 1'b1;

    // CPU halted on $0300 while the host writes $0301.
    cpu_fix_addr = 16'h0300;
    repeat (4) @(posedge clk_25);
    rd_before = cpu_rd_chks;
    last_cpu_rd = 8'h00;
    host_seq(1, 1'b1, 16'h0301, 8'h77, 1'b1, n0);
    repeat (6) @(posedge clk_25);
    chk("halted_read_done", cpu_rd_chks - rd_before > 0, 1);
    chk("halted_read_c3", last_cpu_rd, 8'hC3);
    chk("wram_0301", mem[16'h0301], 8'h77);

    // Request lands on the first of a 3-write push.
    cpu_fix_addr = 16'h0000;
    repeat (3) @(posedge clk_25);
    #2;
    force_push = 3;
    host_seq(1, 1'b1, 16'h0302, 8'h99, 1'b0, n0);
    repeat (4) @(negedge clk_25);
    chk("push_stall_held", grant_log[n0 + 3], 0);
    chk("push_grant", grant_log[n0 + 4], 1);

    // Burst of 4 writes.
    repeat (3) @(posedge clk_25);
    host_seq(4, 1'b1, 16'h0200, 8'h01, 1'b1, n0);
    repeat (5) @(negedge clk_25);
    begin
      int lows;
      lows = 0;
      for (int k = 1; k <= 19; k++) if (!rdy_log[n0 + k]) lows++;
      chk("burst_rdy_low_cycles", lows, 18);
      chk("burst_rdy_back", rdy_log[n0 + 19], 1);
    end
    for (int k = 0; k < 4; k++) chk("burst_wram", mem[16'h0200 + 16'(k)], k + 1);

    // Random traffic.
    cpu_mode = 1;
    ext_rand = 1'b1;
    for (int op = 0; op < 40; op++) begin
      host_seq($urandom_range(1, 3), 1'($urandom_range(0, 1)),
               16'h0310 + 16'($urandom_range(0, 12)), 8'($urandom), 1'b0, n0);
      repeat ($urandom_range(0, 8)) @(posedge clk_25);
    end
    ext_rand = 1'b0;
    cpu_mode = 0;
    ext_rdy_in = 1'b1;
    repeat (20) @(posedge clk_25);
    chk("sb_empty", sb.size(), 0);
    chk("cpu_writes_once", cpu_strobes, cpu_wr_issued);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Shares the NES CPU-side bus (WRAM, PPU register port, cart PRG) between the rp2a03 CPU and a single host master, e.g. a debug or save-state port. On a host request it stalls the CPU through RDY, waits until the 6502 is frozen in a read cycle, and runs single-byte host accesses on the bus. It then hands the bus back with a refetch cycle so the CPU's halted read completes with correct data. It sits between rp2a03 and the address/data/r_nw fan-out in NES_DragonBoard.

## Interface
- No parameters.
- clk_25  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_a_in  in  16  rp2a03 address
- cpu_d_in  in  8  rp2a03 write data
- cpu_r_nw_in  in  1  rp2a03 read/not-write
- ext_rdy_in  in  1  external RDY request (debug button), ANDed into rdy_out
- rdy_out  out  1  to rp2a03 rdy_in
- bus_a_out  out  16  address to WRAM/PPU/cart decode
- bus_d_out  out  8  write data to WRAM/PPU/cart
- bus_r_nw_out  out  1  read/not-write to WRAM/PPU/cart
- bus_d_in  in  8  merged read data (the to_cpu OR-bus)
- host_req  in  1  level request; host_we/host_a/host_d held stable until host_ack
- host_we  in  1  1 = write, 0 = read
- host_a  in  16  host address
- host_d  in  8  host write data
- host_ack  out  1  one-cycle completion pulse
- host_q  out  8  read data; valid while host_ack = 1, held until the next capture
- grant_out  out  1  high while the host owns the bus (ACCESS through GAP)

## Operation
- States: IDLE, STALL, ACCESS, DATA, ACK, GAP, RELEASE.
- rdy_out = ext_rdy_in & rdy_int. rdy_int is a registered signal: 1 in IDLE, 0 in every other state.
- Bus mux: in IDLE, STALL and RELEASE, bus_* = cpu_*. In ACCESS, DATA, ACK and GAP, bus_a_out = host_a and bus_d_out = host_d.
- bus_r_nw_out in host-owned states: ~host_we in ACCESS only, 1 in DATA, ACK and GAP. Exactly one write-strobe cycle per host write.
- IDLE: host_req = 1 → STALL.
- STALL: cpu_r_nw_in = 1 sampled while rdy_int = 0 → ACCESS. The CPU is now frozen repeating that read. Otherwise stay. The 6502 issues at most 3 consecutive writes, so STALL lasts at most 4 cycles.
- ACCESS: address (and write strobe) presented; synchronous RAMs register them at the end of this cycle → DATA.
- DATA: bus_d_in valid; host_q <= bus_d_in at the end of the cycle. For writes the captured value is don't-care → ACK.
- ACK: host_ack = 1 → GAP.
- GAP: host_req = 1 → ACCESS (back-to-back burst, CPU stays stalled); else → RELEASE.
- RELEASE: bus returns to the CPU address with rdy still low, so the RAMs refetch the CPU's pending read → IDLE.
- Dropping host_req after STALL entry does not abort; the access completes and acks.
- PPU register reads have side effects. A CPU halted on a $2002/$2007 read repeats that read every stalled cycle. This is accepted behaviour, matching real RDY.
- ext_rdy_in = 0 does not affect the FSM. The host may proceed once the CPU is in a read.

## Timing
- Reset values: state IDLE, rdy_int 1 (rdy_out = ext_rdy_in), host_ack 0, host_q 8'h00, grant_out 0, bus_* = cpu_*.
- Single access, CPU reading, host_req first high in cycle N (IDLE):
  - STALL in N+1
  - ACCESS in N+2
  - DATA in N+3
  - ACK in N+4
  - GAP in N+5
  - RELEASE in N+6
  - IDLE with rdy_out = 1 in N+7
- Burst: each further byte costs 4 cycles (ACCESS, DATA, ACK, GAP).
- Asynchronous rst mid-transaction: immediate return to IDLE, bus to CPU, no ack. Any write strobe already issued stands.

## Test plan
- CPU in a read loop on $0000. Host writes 8'h5A to $0123. Required: rdy_out low N+1..N+6, bus_r_nw_out = 0 only in N+2 with bus_a_out = 16'h0123, host_ack in N+4, WRAM[$123] = 8'h5A, and the CPU resumes with a correct read.
- Host reads $0123 after that write → host_q = 8'h5A while host_ack = 1.
- Request arrives while the CPU does a 3-write stack push. Required: STALL holds until cpu_r_nw_in = 1, and no CPU write is lost or duplicated.
- Burst of 4 writes $0200-$0203 = 1,2,3,4 with host_req held. Required: ack period 4 cycles, one RELEASE at the end, rdy low for the whole burst.
- Halted CPU read at $0300 (containing 8'hC3) while the host writes $0301. After RELEASE the CPU latches 8'hC3, not host data.
- rst asserted in DATA. Required: next cycle IDLE, rdy_out = ext_rdy_in, host_ack never pulses, host_q = 8'h00.
